// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one AES core between NUM_REQ requesters.
// A watchdog bounds each core run; a timed-out run flushes the core and is reported with rsp_err.
module aes_core_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 128,
  parameter int KEY_W   = 128,
  parameter int TIMEOUT = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*KEY_W-1:0]  req_key,
  input  logic [NUM_REQ*DATA_W-1:0] req_text,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_text,
  output logic                      rsp_err,
  output logic                      core_ld,
  output logic [KEY_W-1:0]          core_key,
  output logic [DATA_W-1:0]         core_text_in,
  output logic                      core_rst_n,
  input  logic                      core_done,
  input  logic [DATA_W-1:0]         core_text_out
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FLUSH, S_RESP} state_t;

  state_t              state;
  logic [ID_W-1:0]     last_grant;
  logic [CNT_W-1:0]    cnt;
  logic [KEY_W-1:0]    key_q;
  logic [DATA_W-1:0]   text_q;
  logic [ID_W-1:0]     id_q;
  logic [DATA_W-1:0]   rsp_text_q;
  logic                rsp_err_q;
  logic [ID_W-1:0]     grant;
  logic [ID_W-1:0]     cand;
  logic                grant_vld;

  // First requester at or after last_grant+1, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant     = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == S_IDLE && grant_vld) req_ready[grant] = 1'b1;
  end

  // Everything is forced low while rst is held, including the core reset.
  assign core_ld      = ~rst & (state == S_LOAD);
  assign core_rst_n   = ~rst & (state != S_FLUSH);
  assign rsp_valid    = ~rst & (state == S_RESP);
  assign rsp_id       = rst ? '0 : id_q;
  assign rsp_text     = rst ? '0 : rsp_text_q;
  assign rsp_err      = ~rst & rsp_err_q;
  assign core_key     = rst ? '0 : key_q;
  assign core_text_in = rst ? '0 : text_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      cnt        <= '0;
      key_q      <= '0;
      text_q     <= '0;
      id_q       <= '0;
      rsp_text_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            key_q      <= req_key[int'(grant) * KEY_W +: KEY_W];
            text_q     <= req_text[int'(grant) * DATA_W +: DATA_W];
            id_q       <= grant;
            last_grant <= grant;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          cnt <= cnt + CNT_W'(1);
          // A done landing on the last watchdog cycle still counts as success.
          if (core_done) begin
            rsp_text_q <= core_text_out;
            rsp_err_q  <= 1'b0;
            state      <= S_RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_text_q <= '0;
            rsp_err_q  <= 1'b1;
            state      <= S_FLUSH;
          end
        end
        S_FLUSH: state <= S_RESP;
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Scoreboard bench: stimulus/reference model push expected responses, a negedge monitor pops and checks.
module tb_aes_core_arbiter;
  localparam int N = 4;
  localparam int W = 128;
  localparam int TO = 32;
  localparam logic [127:0] KN_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KN_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KN_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*W-1:0] req_key, req_text;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err, core_ld, core_rst_n;
  logic [1:0] rsp_id;
  logic [W-1:0] rsp_text, core_key, core_text_in;
  logic core_done = 1'b0;
  logic [W-1:0] core_text_out = '0;

  aes_core_arbiter #(.NUM_REQ(N), .DATA_W(W), .KEY_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_text(req_text), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_text(rsp_text), .rsp_err(rsp_err), .core_ld(core_ld),
    .core_key(core_key), .core_text_in(core_text_in), .core_rst_n(core_rst_n),
    .core_done(core_done), .core_text_out(core_text_out));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] rk[N], rt[N];
  always_comb begin
    req_key = '0;
    req_text = '0;
    for (int i = 0; i < N; i++) begin
      req_key[i*W +: W]  = rk[i];
      req_text[i*W +: W] = rt[i];
    end
  end

  typedef struct {int id; logic [W-1:0] text; bit err; int rise;} exp_t;
  exp_t exp_arr[1024];
  int grant_cnt = 0, rsp_seen = 0, checks = 0, errors = 0;
  int grant_log[$];
  int last_m = N - 1, last_hs = -1000, flush_cyc = -1000, drop_id = -1, stray_at = -1;
  logic [W-1:0] hs_key, hs_text;
  bit hold_all = 0, gen_en = 0, rand_rdy = 0, rdy_next = 0, rst_next = 1;
  bit [N-1:0] inj_vld = '0;
  logic [W-1:0] inj_key[N], inj_text[N];

  // Core stand-in: latency is encoded in the key; top byte EE means the core hangs.
  function automatic int lat_of(input logic [W-1:0] k);
    int l;
    if (k[127:120] == 8'hEE) return 10000;
    l = int'(k[5:0] ^ 6'h03);
    return (l == 0) ? 1 : l;
  endfunction

  function automatic logic [W-1:0] ct_of(input logic [W-1:0] k, input logic [W-1:0] t);
    if (k == KN_KEY && t == KN_PT) return KN_CT;
    return k ^ {t[63:0], t[127:64]} ^ 128'h5a5a_5a5a_a5a5_a5a5_3c3c_3c3c_c3c3_c3c3;
  endfunction

  function automatic logic [W-1:0] mk_key(input int lat);
    logic [W-1:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    if (lat > 63) begin
      k[127:120] = 8'hEE;
    end else begin
      if (k[127:120] == 8'hEE) k[127:120] = 8'h11;
      k[5:0] = 6'(lat) ^ 6'h03;
    end
    return k;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input int i, input logic [W-1:0] k, input logic [W-1:0] t);
    inj_vld[i] = 1'b1;
    inj_key[i] = k;
    inj_text[i] = t;
  endtask

  // One clock: apply inputs at +1, evaluate the reference model at +3.
  task automatic step();
    int w;
    logic [N-1:0] exp_ready;
    exp_t e;
    @(posedge clk); #1;
    rst = rst_next;
    rsp_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_next;
    if (drop_id >= 0) begin
      if (hold_all) begin
        rk[drop_id] = mk_key($urandom_range(1, 8));
        rt[drop_id] = {$urandom, $urandom, $urandom, $urandom};
      end else req_valid[drop_id] = 1'b0;
      drop_id = -1;
    end
    for (int i = 0; i < N; i++) begin
      if (inj_vld[i]) begin
        rk[i] = inj_key[i]; rt[i] = inj_text[i]; req_valid[i] = 1'b1; inj_vld[i] = 1'b0;
      end else if (gen_en && !req_valid[i] && $urandom_range(0, 3) == 0) begin
        rk[i] = mk_key(($urandom_range(0, 15) == 0) ? 1000 : $urandom_range(1, 40));
        rt[i] = {$urandom, $urandom, $urandom, $urandom};
        req_valid[i] = 1'b1;
      end
    end
    #2;
    if (rst) begin
      chk("rst_ctrl", 128'({req_ready, rsp_valid, rsp_err, core_ld, core_rst_n, rsp_id}), '0);
      chk("rst_data", rsp_text | core_key | core_text_in, '0);
      grant_cnt = rsp_seen;
      last_m = N - 1; last_hs = -1000; flush_cyc = -1000;
    end else begin
      chk("core_ld", 128'(core_ld), 128'(cyc == last_hs + 1));
      if (cyc == last_hs + 1) begin
        chk("core_key", core_key, hs_key);
        chk("core_text_in", core_text_in, hs_text);
      end
      chk("core_rst_n", 128'(core_rst_n), 128'(cyc != flush_cyc));
      w = -1;
      exp_ready = '0;
      if (grant_cnt == rsp_seen)
        for (int k = 1; k <= N; k++)
          if (w < 0 && req_valid[(last_m + k) % N]) w = (last_m + k) % N;
      if (w >= 0) exp_ready[w] = 1'b1;
      chk("req_ready", 128'(req_ready), 128'(exp_ready));
      if (w >= 0) begin
        e.id = w;
        e.err = lat_of(rk[w]) > TO;
        e.text = e.err ? '0 : ct_of(rk[w], rt[w]);
        e.rise = e.err ? cyc + TO + 3 : cyc + lat_of(rk[w]) + 2;
        if (e.err) flush_cyc = cyc + TO + 2;
        exp_arr[grant_cnt % 1024] = e;
        grant_cnt++;
        last_m = w; last_hs = cyc; hs_key = rk[w]; hs_text = rt[w];
        grant_log.push_back(w);
        drop_id = w;
      end
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((grant_cnt != rsp_seen || req_valid != '0 || inj_vld != '0) && n < bound) begin
      step();
      n++;
    end
    if (n >= bound) begin
      checks++; errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles", bound);
    end
  endtask

  // Core model
  initial begin
    bit busy = 0;
    int cd = 0;
    logic [W-1:0] ck = '0, ctx = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      core_text_out = {$urandom, $urandom, $urandom, $urandom};
      if (!core_rst_n) busy = 0;
      else if (busy) begin
        cd--;
        if (cd == 0) begin
          core_done = 1'b1; core_text_out = ct_of(ck, ctx); busy = 0;
        end
      end
      if (core_ld) begin
        busy = 1; cd = lat_of(core_key); ck = core_key; ctx = core_text_in;
      end
      if (cyc == stray_at) core_done = 1'b1;
    end
  end

  // Response monitor
  initial begin
    bit prev = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid) begin
        if (grant_cnt == rsp_seen) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: id %0d err %0b with nothing outstanding (cycle %0d)", rsp_id, rsp_err, cyc);
        end else begin
          e = exp_arr[rsp_seen % 1024];
          if (!prev) chk("rsp_rise_cycle", 128'(cyc), 128'(e.rise));
          chk("rsp_id", 128'(rsp_id), 128'(e.id));
          chk("rsp_text", rsp_text, e.text);
          chk("rsp_err", 128'(rsp_err), 128'(e.err));
          if (rsp_ready) rsp_seen++;
        end
      end
      prev = !rst && rsp_valid && !rsp_ready;
    end
  end

  initial begin
    int ro[5] = '{0, 1, 2, 3, 0};
    int n, base;
    for (int i = 0; i < N; i++) begin rk[i] = '0; rt[i] = '0; inj_key[i] = '0; inj_text[i] = '0; end
    repeat (3) step();
    rst_next = 0; rdy_next = 1;
    step();

    // Round-robin under full contention
    hold_all = 1;
    for (int i = 0; i < N; i++) issue(i, mk_key($urandom_range(1, 8)), {$urandom, $urandom, $urandom, $urandom});
    n = 0;
    while (grant_log.size() < 5 && n < 300) begin step(); n++; end
    hold_all = 0;
    for (int i = 0; i < 5; i++)
      if (i < grant_log.size()) chk("rr_order", 128'(grant_log[i]), 128'(ro[i]));
      else begin checks++; errors++; $display("FAIL rr_order: only %0d grants", grant_log.size()); end
    wait_idle(500);

    // Single request, FIPS-197 vector
    base = rsp_seen;
    issue(2, KN_KEY, KN_PT);
    wait_idle(100);
    chk("single_rsp_count", 128'(rsp_seen), 128'(base + 1));

    // Backpressure with a second requester waiting
    rdy_next = 0;
    issue(1, mk_key(5), {$urandom, $urandom, $urandom, $urandom});
    issue(3, mk_key(5), {$urandom, $urandom, $urandom, $urandom});
    n = 0;
    while (!rsp_valid && n < 100) begin step(); n++; end
    repeat (10) step();
    rdy_next = 1;
    wait_idle(100);

    // Hung core, then a normal request
    issue(0, mk_key(1000), {$urandom, $urandom, $urandom, $urandom});
    wait_idle(200);
    issue(0, KN_KEY, KN_PT);
    wait_idle(100);

    // Done on the last watchdog cycle, then one cycle too late
    issue(1, mk_key(TO), {$urandom, $urandom, $urandom, $urandom});
    wait_idle(200);
    issue(1, mk_key(TO + 1), {$urandom, $urandom, $urandom, $urandom});
    wait_idle(200);

    // Stray done while idle
    base = rsp_seen;
    stray_at = cyc + 2;
    repeat (6) step();
    chk("stray_no_rsp", 128'(rsp_seen), 128'(base));
    issue(2, mk_key(7), {$urandom, $urandom, $urandom, $urandom});
    wait_idle(100);

    // Reset in the middle of RUN
    base = rsp_seen;
    n = grant_cnt;
    issue(3, mk_key(20), {$urandom, $urandom, $urandom, $urandom});
    while (grant_cnt == n && n < 1000) begin step(); end
    repeat (4) step();
    rst_next = 1;
    step();
    rst_next = 0;
    repeat (30) step();
    chk("abort_no_rsp", 128'(rsp_seen), 128'(base));
    n = grant_log.size();
    for (int i = 0; i < N; i++) issue(i, mk_key(3), {$urandom, $urandom, $urandom, $urandom});
    step(); step();
    if (grant_log.size() > n) chk("post_reset_first", 128'(grant_log[n]), 128'(0));
    else begin checks++; errors++; $display("FAIL post_reset_first: no grant after reset"); end
    wait_idle(200);

    // Random traffic with random backpressure
    gen_en = 1; rand_rdy = 1;
    repeat (3000) step();
    gen_en = 0; rand_rdy = 0; rdy_next = 1;
    wait_idle(3000);
    chk("all_responses", 128'(rsp_seen), 128'(grant_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
